// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin share of one MULDIV unit between the
// integer M path (id 0) and the F mantissa path (id 1).
module muldiv_arbiter #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstLow,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_rs1_i,
  input  logic [31:0]      req0_rs2_i,
  input  logic [2:0]       req0_funct3_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_rs1_i,
  input  logic [31:0]      req1_rs2_i,
  input  logic [2:0]       req1_funct3_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_err_o,
  output logic             md_start_o,
  output logic [31:0]      md_rs1_o,
  output logic [31:0]      md_rs2_o,
  output logic [2:0]       md_funct3_o,
  input  logic [31:0]      md_c_i,
  input  logic             md_busy_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic             r_rr;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  logic [2:0]       r_f3;
  logic [TAG_W-1:0] r_tag;
  logic             r_id;
  logic [31:0]      r_data;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  logic w_gnt0;
  logic w_gnt1;
  logic w_hs;
  logic w_expire;

  // r_rr=1 means requester 1 is preferred this round
  assign w_gnt0 = req0_valid_i && (!r_rr || !req1_valid_i);
  assign w_gnt1 = req1_valid_i && !w_gnt0;
  assign w_hs   = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);

  assign w_expire = (TIMEOUT != 0) && (r_cnt == LIMIT);

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_gnt0 || w_gnt1) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_CHECK;
      S_CHECK:   w_next = md_busy_i ? S_WAIT : S_CAPTURE;
      S_WAIT: begin
        if (!md_busy_i)    w_next = S_CAPTURE;
        else if (w_expire) w_next = S_DONE;
      end
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    if (rsp_ready_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    md_start_o   = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready_o = w_gnt0 && rstLow;
        req1_ready_o = w_gnt1 && rstLow;
      end
      S_ISSUE: md_start_o  = 1'b1;
      S_DONE:  rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_rr   <= 1'b0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_f3   <= '0;
      r_tag  <= '0;
      r_id   <= 1'b0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_hs) begin
        r_rs1 <= w_gnt0 ? req0_rs1_i : req1_rs1_i;
        r_rs2 <= w_gnt0 ? req0_rs2_i : req1_rs2_i;
        r_f3  <= w_gnt0 ? req0_funct3_i : req1_funct3_i;
        r_tag <= w_gnt0 ? req0_tag_i : req1_tag_i;
        r_id  <= w_gnt1;
        r_rr  <= w_gnt0;
      end
      case (r_state)
        S_CHECK: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (md_busy_i && w_expire) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_data <= md_c_i;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign md_rs1_o    = r_rs1;
  assign md_rs2_o    = r_rs2;
  assign md_funct3_o = r_f3;
  assign rsp_id_o    = r_id;
  assign rsp_tag_o   = r_tag;
  assign rsp_data_o  = r_data;
  assign rsp_err_o   = r_err;

endmodule
